// File: rtl/sm4_round_iterator.sv
// SM4 round iterator: sequential controller wrapped around the combinational
// turn_transform. Loads a block (or MK^FK in key mode) into a word-shift
// state register, runs one transform pass per cycle for rounds_p rounds, then
// holds the word-reversed final state until it is consumed.
// Optional build macro: SM4_ITER_ZEROIZE_EN clears state/mask/dismask on the
// yumi_i handshake so data_o reads 0 once back in IDLE.
//
// Handshakes: input side is valid/ready (transfer on v_i & ready_o, ready_o
// high only in IDLE); output side is valid/yumi (v_o high only in DONE, the
// consumer pulses yumi_i while v_o=1 to take the result; yumi_i with v_o=0 is
// ignored).
module sm4_round_iterator #(
  parameter int rounds_p     = 32,
  parameter int group_size_p = 128,
  parameter int word_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [group_size_p-1:0] data_i,
  input  logic                    is_key_i,
  input  logic                    decrypt_i,
  input  logic [word_width_p-1:0] mask_seed_i,
  output logic [4:0]              rkey_addr_o,
  input  logic [word_width_p-1:0] rkey_i,
  output logic [group_size_p-1:0] tf_i_o,
  output logic                    tf_is_key_o,
  output logic [word_width_p-1:0] tf_rkey_o,
  output logic [word_width_p-1:0] tf_mask_o,
  output logic [word_width_p-1:0] tf_dismask_o,
  input  logic [word_width_p-1:0] tf_o_i,
  input  logic [word_width_p-1:0] tf_mask_i,
  output logic                    rk_v_o,
  output logic [4:0]              rk_addr_o,
  output logic [word_width_p-1:0] rk_o,
  output logic                    v_o,
  output logic [group_size_p-1:0] data_o,
  input  logic                    yumi_i,
  output logic [1:0]              dbg_state_o
);

  localparam int         words_lp = group_size_p / word_width_p;
  localparam logic [4:0] last_lp  = 5'(rounds_p - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  r_state;
  state_e                  w_state_n;
  logic [group_size_p-1:0] r_blk;
  logic [group_size_p-1:0] w_data_rev;
  logic [4:0]              r_cnt;
  logic [word_width_p-1:0] r_mask;
  logic [word_width_p-1:0] r_dismask;
  logic                    r_is_key;
  logic                    r_decrypt;
  logic                    w_run;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_release;

  assign w_run     = (r_state == ST_RUN);
  assign ready_o   = (r_state == ST_IDLE);
  assign v_o       = (r_state == ST_DONE);
  assign w_accept  = v_i & ready_o;
  assign w_last    = w_run & (r_cnt == last_lp);
  assign w_release = v_o & yumi_i;

  // Word-reverse the incoming block so X0 sits in the low word of the state.
  always_comb begin
    w_data_rev = '0;
    for (int w = 0; w < words_lp; w++) begin
      w_data_rev[w*word_width_p +: word_width_p] =
        data_i[(words_lp-1-w)*word_width_p +: word_width_p];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= ST_IDLE;
    else            r_state <= w_state_n;
  end

  // FSM next-state: accept in IDLE, leave RUN after the last round, release on yumi.
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      ST_IDLE: if (v_i)    w_state_n = ST_RUN;
      ST_RUN:  if (w_last) w_state_n = ST_DONE;
      ST_DONE: if (yumi_i) w_state_n = ST_IDLE;
      default:             w_state_n = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, shift in one transform result per RUN cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_blk     <= '0;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_dismask <= '0;
      r_is_key  <= 1'b0;
      r_decrypt <= 1'b0;
    end else if (w_accept) begin
      r_blk     <= w_data_rev;
      r_cnt     <= '0;
      r_mask    <= mask_seed_i;
      r_dismask <= '0;
      r_is_key  <= is_key_i;
      // Key expansion always walks CK forwards, so the reverse flag is dropped.
      r_decrypt <= decrypt_i & ~is_key_i;
    end else if (w_run) begin
      r_blk     <= {tf_o_i, r_blk[group_size_p-1:word_width_p]};
      r_dismask <= tf_mask_i;
      // Hold at the last index instead of wrapping; RUN ends there anyway.
      r_cnt     <= w_last ? r_cnt : r_cnt + 5'd1;
`ifdef SM4_ITER_ZEROIZE_EN
    end else if (w_release) begin
      r_blk     <= '0;
      r_mask    <= '0;
      r_dismask <= '0;
`endif
    end
  end

  // Transform drive and round-key request are only live during RUN.
  assign rkey_addr_o  = w_run ? (r_decrypt ? (last_lp - r_cnt) : r_cnt) : 5'd0;
  assign tf_i_o       = w_run ? r_blk : '0;
  assign tf_is_key_o  = w_run & r_is_key;
  assign tf_rkey_o    = w_run ? rkey_i : '0;
  assign tf_mask_o    = w_run ? r_mask : '0;
  assign tf_dismask_o = w_run ? r_dismask : '0;

  // Key-mode round-key stream straight from the transform output.
  assign rk_v_o    = w_run & r_is_key;
  assign rk_addr_o = rk_v_o ? r_cnt : 5'd0;
  assign rk_o      = rk_v_o ? tf_o_i : '0;

  assign data_o      = r_blk;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_sm4_round_iterator.sv
// Testbench for sm4_round_iterator: models turn_transform (unmasked SM4 round
// plus a simple mask evolution) and checks GB/T 32907 vectors, key mode,
// backpressure, throughput and asynchronous reset.
module tb_sm4_round_iterator;

  localparam logic [127:0] MK = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] FK = 128'ha3b1bac656aa3350677d9197b27022dc;
  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  // Clock / reset and DUT signals
  logic         clk = 1'b0;
  logic         reset_n_i;
  logic         v_i, ready_o, is_key_i, decrypt_i, yumi_i, v_o;
  logic [127:0] data_i, data_o, tf_i_o;
  logic [31:0]  mask_seed_i, rkey_i, tf_rkey_o, tf_mask_o, tf_dismask_o;
  logic [31:0]  tf_o_i, tf_mask_i, rk_o;
  logic [4:0]   rkey_addr_o, rk_addr_o;
  logic         tf_is_key_o, rk_v_o;
  logic [1:0]   dbg_state_o;

  logic [31:0]  rk_tab  [32];
  logic [31:0]  rk_seen [32];
  logic         tb_key_mode = 1'b0;
  time          t_accept;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  sm4_round_iterator dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
    .data_i(data_i), .is_key_i(is_key_i), .decrypt_i(decrypt_i),
    .mask_seed_i(mask_seed_i), .rkey_addr_o(rkey_addr_o), .rkey_i(rkey_i),
    .tf_i_o(tf_i_o), .tf_is_key_o(tf_is_key_o), .tf_rkey_o(tf_rkey_o),
    .tf_mask_o(tf_mask_o), .tf_dismask_o(tf_dismask_o), .tf_o_i(tf_o_i),
    .tf_mask_i(tf_mask_i), .rk_v_o(rk_v_o), .rk_addr_o(rk_addr_o), .rk_o(rk_o),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .dbg_state_o(dbg_state_o)
  );

  // SM4 reference pieces
  function automatic logic [31:0] rol(input logic [31:0] a, input int n);
    return (a << n) | (a >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] lin(input logic [31:0] b);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] lin_key(input logic [31:0] b);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  function automatic logic [31:0] ck_of(input int i);
    logic [31:0] r;
    int          v;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      v = ((4 * i + j) * 7) % 256;
      r[31 - 8*j -: 8] = v[7:0];
    end
    return r;
  endfunction

  // One unmasked round: low word is X_i, upper three words feed T.
  function automatic logic [31:0] sm4_round(input logic [127:0] s, input logic [31:0] rk, input logic k);
    logic [31:0] t;
    t = tau(s[63:32] ^ s[95:64] ^ s[127:96] ^ rk);
    return s[31:0] ^ (k ? lin_key(t) : lin(t));
  endfunction

  function automatic logic [31:0] mask_fn(input logic [31:0] m);
    return {m[30:0], m[31]} ^ 32'h9e3779b9;
  endfunction

  // turn_transform and round-key store models
  assign tf_o_i    = sm4_round(tf_i_o, tf_rkey_o, tf_is_key_o);
  assign tf_mask_i = mask_fn(tf_mask_o);
  assign rkey_i    = tb_key_mode ? ck_of(int'(rkey_addr_o)) : rk_tab[rkey_addr_o];

  task automatic build_tables();
    logic [31:0]  k [36];
    logic [127:0] kf;
    kf = MK ^ FK;
    k[0] = kf[127:96]; k[1] = kf[95:64]; k[2] = kf[63:32]; k[3] = kf[31:0];
    for (int i = 0; i < 32; i++) begin
      k[i+4]    = k[i] ^ lin_key(tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_of(i)));
      rk_tab[i] = k[i+4];
    end
  endtask

  // Driver: accept one block starting at a negedge, then check every RUN
  // cycle. Returns at the DONE negedge, or at RUN round abort_at.
  task automatic run_op(input logic [127:0] din, input logic key, input logic dec,
                        input logic [31:0] seed, input int abort_at, output int cyc);
    logic [31:0] exp_dis;
    logic [31:0] exp_rkey;
    logic [4:0]  e_addr;
    bit          aborted;
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_before_accept: got %b need 1", ready_o); end
    tb_key_mode = key;
    v_i = 1'b1; data_i = din; is_key_i = key; decrypt_i = dec; mask_seed_i = seed;
    @(posedge clk);
    t_accept = $time;
    #1;
    v_i = 1'b0; data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    is_key_i = ~key; decrypt_i = ~dec; mask_seed_i = $urandom();
    exp_dis = '0; cyc = 0; aborted = 1'b0;
    @(negedge clk);
    while (v_o !== 1'b1 && cyc < 40) begin
      if (cyc == abort_at) begin aborted = 1'b1; break; end
      e_addr   = (dec && !key) ? 5'(31 - cyc) : 5'(cyc);
      exp_rkey = key ? ck_of(cyc) : rk_tab[e_addr];
      n_checks += 5;
      if (rkey_addr_o !== e_addr) begin n_fail++; $display("FAIL rkey_addr r%0d: got %0d need %0d", cyc, rkey_addr_o, e_addr); end
      if (tf_rkey_o !== exp_rkey) begin n_fail++; $display("FAIL tf_rkey r%0d: got %h need %h", cyc, tf_rkey_o, exp_rkey); end
      if (tf_mask_o !== seed) begin n_fail++; $display("FAIL tf_mask r%0d: got %h need %h", cyc, tf_mask_o, seed); end
      if (tf_dismask_o !== exp_dis) begin n_fail++; $display("FAIL tf_dismask r%0d: got %h need %h", cyc, tf_dismask_o, exp_dis); end
      if (ready_o !== 1'b0 || tf_is_key_o !== key || rk_v_o !== key) begin
        n_fail++; $display("FAIL run_flags r%0d: got ready=%b is_key=%b rk_v=%b need 0/%b/%b", cyc, ready_o, tf_is_key_o, rk_v_o, key, key);
      end
      if (key) begin
        n_checks += 2;
        if (rk_addr_o !== 5'(cyc)) begin n_fail++; $display("FAIL rk_addr r%0d: got %0d need %0d", cyc, rk_addr_o, cyc); end
        if (cyc < 32) begin
          rk_seen[cyc] = rk_o;
          if (rk_o !== rk_tab[cyc]) begin n_fail++; $display("FAIL rk_o r%0d: got %h need %h", cyc, rk_o, rk_tab[cyc]); end
        end
      end
      exp_dis = mask_fn(seed);
      @(negedge clk);
      cyc++;
    end
    if (!aborted) begin
      n_checks++;
      if (cyc != 32) begin n_fail++; $display("FAIL latency: got %0d run cycles need 32", cyc); end
    end
  endtask

  // Driver: check DONE, optionally stall with yumi_i low, then release.
  task automatic finish_op(input logic [127:0] exp_data, input int hold);
    logic [127:0] exp_idle;
    n_checks += 2;
    if (v_o !== 1'b1 || ready_o !== 1'b0) begin n_fail++; $display("FAIL done_flags: got v=%b ready=%b need 1/0", v_o, ready_o); end
    if (data_o !== exp_data) begin n_fail++; $display("FAIL done_data: got %h need %h", data_o, exp_data); end
    for (int i = 0; i < hold; i++) begin
      v_i = (i == 3); data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      n_checks += 2;
      if (v_o !== 1'b1 || ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_flags c%0d: got v=%b ready=%b need 1/0", i, v_o, ready_o); end
      if (data_o !== exp_data) begin n_fail++; $display("FAIL stall_data c%0d: got %h need %h", i, data_o, exp_data); end
    end
    v_i = 1'b0; yumi_i = 1'b1;
    @(posedge clk);
    #1 yumi_i = 1'b0;
    @(negedge clk);
`ifdef SM4_ITER_ZEROIZE_EN
    exp_idle = '0;
`else
    exp_idle = exp_data;
`endif
    n_checks += 2;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin n_fail++; $display("FAIL release_flags: got ready=%b v=%b need 1/0", ready_o, v_o); end
    if (data_o !== exp_idle) begin n_fail++; $display("FAIL idle_data: got %h need %h", data_o, exp_idle); end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
    is_key_i = 1'b0; decrypt_i = 1'b0; mask_seed_i = '0;
    repeat (2) @(negedge clk);
    n_checks += 4;
    if (ready_o !== 1'b1 || v_o !== 1'b0 || rk_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ready=%b v=%b rk_v=%b need 1/0/0", ready_o, v_o, rk_v_o); end
    if (data_o !== '0 || tf_i_o !== '0) begin n_fail++; $display("FAIL reset_data: got data=%h tf_i=%h need 0", data_o, tf_i_o); end
    if (rkey_addr_o !== 5'd0 || tf_rkey_o !== '0 || tf_mask_o !== '0 || tf_dismask_o !== '0 || tf_is_key_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_tf: got addr=%0d rkey=%h mask=%h dis=%h key=%b need 0", rkey_addr_o, tf_rkey_o, tf_mask_o, tf_dismask_o, tf_is_key_o);
    end
    if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d need 0", dbg_state_o); end
    reset_n_i = 1'b1;
    // yumi_i in IDLE must be ignored
    yumi_i = 1'b1;
    @(negedge clk);
    yumi_i = 1'b0;
    n_checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin n_fail++; $display("FAIL idle_yumi: got ready=%b v=%b need 1/0", ready_o, v_o); end
  endtask

  task automatic test_key_mode();
    int cyc;
    // decrypt_i=1 must not reverse CK order in key mode
    run_op(MK ^ FK, 1'b1, 1'b1, 32'h12345678, -1, cyc);
    n_checks += 2;
    if (rk_seen[0] !== 32'hf12186f9) begin n_fail++; $display("FAIL rk0: got %h need f12186f9", rk_seen[0]); end
    if (rk_seen[31] !== 32'h9124a012) begin n_fail++; $display("FAIL rk31: got %h need 9124a012", rk_seen[31]); end
    finish_op({rk_tab[31], rk_tab[30], rk_tab[29], rk_tab[28]}, 0);
  endtask

  task automatic test_encrypt();
    int cyc;
    run_op(PT, 1'b0, 1'b0, 32'hdeadbeef, -1, cyc);
    finish_op(CT, 0);
  endtask

  task automatic test_decrypt();
    int cyc;
    run_op(CT, 1'b0, 1'b1, 32'h0badf00d, -1, cyc);
    finish_op(PT, 0);
  endtask

  task automatic test_backpressure();
    int cyc;
    run_op(PT, 1'b0, 1'b0, 32'hcafe0001, -1, cyc);
    finish_op(CT, 10);
  endtask

  task automatic test_back_to_back();
    int  cyc;
    time t0;
    run_op(PT, 1'b0, 1'b0, 32'h00000001, -1, cyc);
    t0 = t_accept;
    finish_op(CT, 0);
    run_op(CT, 1'b0, 1'b1, 32'h80000000, -1, cyc);
    n_checks++;
    if (t_accept - t0 != 340) begin n_fail++; $display("FAIL throughput: got %0t between accepts need 340", t_accept - t0); end
    finish_op(PT, 0);
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    run_op(MK ^ FK, 1'b1, 1'b0, 32'h5a5a5a5a, 15, cyc);
    #2 reset_n_i = 1'b0;
    #1;
    n_checks += 3;
    if (ready_o !== 1'b1 || v_o !== 1'b0 || rk_v_o !== 1'b0 || dbg_state_o !== 2'd0) begin
      n_fail++; $display("FAIL async_flags: got ready=%b v=%b rk_v=%b st=%0d need 1/0/0/0", ready_o, v_o, rk_v_o, dbg_state_o);
    end
    if (data_o !== '0 || tf_i_o !== '0) begin n_fail++; $display("FAIL async_data: got data=%h tf_i=%h need 0", data_o, tf_i_o); end
    if (rkey_addr_o !== 5'd0 || tf_rkey_o !== '0 || tf_mask_o !== '0 || tf_dismask_o !== '0) begin
      n_fail++; $display("FAIL async_tf: got addr=%0d rkey=%h mask=%h dis=%h need 0", rkey_addr_o, tf_rkey_o, tf_mask_o, tf_dismask_o);
    end
    @(negedge clk);
    reset_n_i = 1'b1;
    run_op(PT, 1'b0, 1'b0, 32'h13572468, -1, cyc);
    finish_op(CT, 0);
  endtask

  initial begin
    build_tables();
    test_reset();
    test_key_mode();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
